// File: rtl/fb_addr_gen_if.sv
// Sync-strobe inputs and BRAM read-port outputs of the framebuffer address generator.
interface fb_addr_gen_if #(
    parameter int XW     = 10,
    parameter int YW     = 9,
    parameter int ADDR_W = 19
);
    logic              Hsync;
    logic              Vsync;
    logic              Hflip;
    logic              Vflip;
    logic [ADDR_W-1:0] addr;
    logic              de;
    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic              frame_start;
    logic              short_line;

    modport slave (
        input  Hsync, Vsync, Hflip, Vflip,
        output addr, de, x, y, frame_start, short_line
    );
    modport master (
        output Hsync, Vsync, Hflip, Vflip,
        input  addr, de, x, y, frame_start, short_line
    );
endinterface

// File: rtl/fb_addr_gen.sv
// Framebuffer read-address generator recovering pixel position from Hsync/Vsync edges.
// Define FBADDR_HFLIP_EN to build the per-frame horizontal mirror.
module fb_addr_gen #(
    parameter int HSIZE  = 640,
    parameter int VSIZE  = 480,
    parameter int HBP    = 16,
    parameter int VBP    = 10,
    parameter int XW     = 10,
    parameter int YW     = 9,
    parameter int ADDR_W = 19
) (
    input  logic         CLK,
    input  logic         RESET,
    fb_addr_gen_if.slave bus
);
    typedef enum logic [2:0] {V_IDLE, V_SYNC, V_PORCH, V_ACTIVE, V_DONE} v_state_t;
    typedef enum logic [1:0] {H_SYNC, H_PORCH, H_ACTIVE, H_DONE} h_state_t;

    localparam logic [ADDR_W-1:0] BASE_LAST = ADDR_W'((VSIZE - 1) * HSIZE);
    localparam logic [ADDR_W-1:0] HSTEP     = ADDR_W'(HSIZE);
    localparam logic [ADDR_W-1:0] XOFF_LAST = ADDR_W'(HSIZE - 1);
    localparam logic [XW-1:0]     XLAST     = XW'(HSIZE - 1);
    localparam logic [YW-1:0]     YLAST     = YW'(VSIZE - 1);
    localparam logic [7:0]        HBP_C     = 8'(HBP);
    localparam logic [7:0]        VBP_LAST  = 8'(VBP - 1);

    v_state_t          v_st, v_nxt;
    h_state_t          h_st, h_nxt;
    logic              hs_d, vs_d;
    logic [7:0]        hcnt, vcnt;
    logic [XW-1:0]     x_q;
    logic [YW-1:0]     y_q;
    logic [ADDR_W-1:0] base_q, addr_q;
    logic              vf_q, fs_q, short_q, short_nxt;
    logic              hf;

    wire hs      = bus.Hsync;
    wire vs      = bus.Vsync;
    wire hs_fall = hs_d & ~hs;
    wire vs_fall = vs_d & ~vs;

`ifdef FBADDR_HFLIP_EN
    logic hf_q;
    always_ff @(posedge CLK) begin
        if (!RESET)       hf_q <= 1'b0;
        else if (vs_fall) hf_q <= bus.Hflip;
    end
    assign hf = hf_q;
`else
    logic unused_hflip;
    assign unused_hflip = bus.Hflip;
    assign hf = 1'b0;
`endif

    // Vsync low overrides everything, including a coincident Hsync edge.
    always_comb begin
        v_nxt = v_st;
        if (!vs) v_nxt = V_SYNC;
        else begin
            case (v_st)
                V_SYNC:   v_nxt = V_PORCH;
                V_PORCH:  if (hs_fall && vcnt == VBP_LAST) v_nxt = V_ACTIVE;
                V_ACTIVE: if (hs_fall && y_q == YLAST) v_nxt = V_DONE;
                default:  v_nxt = v_st;
            endcase
        end
    end

    always_comb begin
        h_nxt     = h_st;
        short_nxt = 1'b0;
        if (!hs) begin
            h_nxt     = H_SYNC;
            short_nxt = (h_st == H_ACTIVE) && vs;
        end else begin
            case (h_st)
                H_SYNC:   h_nxt = H_PORCH;
                H_PORCH:  if (hcnt == HBP_C)
                              h_nxt = (v_st == V_ACTIVE && vs) ? H_ACTIVE : H_DONE;
                H_ACTIVE: if (!vs || x_q == XLAST) h_nxt = H_DONE;
                default:  h_nxt = h_st;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            v_st    <= V_IDLE;
            h_st    <= H_SYNC;
            hs_d    <= 1'b1;
            vs_d    <= 1'b1;
            hcnt    <= '0;
            vcnt    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            base_q  <= '0;
            addr_q  <= '0;
            vf_q    <= 1'b0;
            fs_q    <= 1'b0;
            short_q <= 1'b0;
        end else begin
            hs_d    <= hs;
            vs_d    <= vs;
            v_st    <= v_nxt;
            h_st    <= h_nxt;
            fs_q    <= vs_fall;
            short_q <= short_nxt;
            if (vs_fall) vf_q <= bus.Vflip;

            if (!vs) begin
                y_q  <= '0;
                vcnt <= '0;
            end else if (v_st == V_SYNC) begin
                vcnt <= '0;
            end else if (v_st == V_PORCH && hs_fall) begin
                vcnt <= vcnt + 8'd1;
                if (v_nxt == V_ACTIVE) begin
                    y_q    <= '0;
                    base_q <= vf_q ? BASE_LAST : '0;
                end
            end else if (v_st == V_ACTIVE && hs_fall && y_q != YLAST) begin
                y_q    <= y_q + YW'(1);
                base_q <= vf_q ? base_q - HSTEP : base_q + HSTEP;
            end

            // Address walks by +/-1 from the line start instead of recomputing base + x.
            case (h_nxt)
                H_SYNC: begin
                    x_q  <= '0;
                    hcnt <= '0;
                end
                H_PORCH: if (h_st == H_PORCH) hcnt <= hcnt + 8'd1;
                H_ACTIVE: begin
                    if (h_st != H_ACTIVE) begin
                        x_q    <= '0;
                        addr_q <= base_q + (hf ? XOFF_LAST : '0);
                    end else begin
                        x_q    <= x_q + XW'(1);
                        addr_q <= hf ? addr_q - ADDR_W'(1) : addr_q + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.addr        = addr_q;
    assign bus.de          = (h_st == H_ACTIVE);
    assign bus.x           = x_q;
    assign bus.y           = y_q;
    assign bus.frame_start = fs_q;
    assign bus.short_line  = short_q;
endmodule

// File: tb/tb_fb_addr_gen.sv
// Directed bench for fb_addr_gen with an 8x4 frame, HBP=2, VBP=1.
module tb_fb_addr_gen;
    logic CLK = 1'b0;
    logic RESET = 1'b0;
    int   checks = 0;
    int   failures = 0;

`ifdef FBADDR_HFLIP_EN
    localparam bit HF_EN = 1'b1;
`else
    localparam bit HF_EN = 1'b0;
`endif

    fb_addr_gen_if #(.XW(3), .YW(2), .ADDR_W(5)) bus ();

    fb_addr_gen #(
        .HSIZE(8), .VSIZE(4), .HBP(2), .VBP(1), .XW(3), .YW(2), .ADDR_W(5)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    logic [4:0] q_addr[$];
    int         q_x[$];
    int         q_y[$];
    int         n_fs = 0;
    int         n_short = 0;

    // One rising edge; outputs are sampled 1 time unit later and logged.
    task automatic tick();
        @(posedge CLK);
        #1;
        if (bus.de === 1'b1) begin
            q_addr.push_back(bus.addr);
            q_x.push_back(int'(bus.x));
            q_y.push_back(int'(bus.y));
        end
        if (bus.frame_start === 1'b1) n_fs++;
        if (bus.short_line === 1'b1) n_short++;
    endtask

    task automatic clear_log();
        q_addr.delete();
        q_x.delete();
        q_y.delete();
        n_fs = 0;
        n_short = 0;
    endtask

    task automatic run_line(input int lo, input int hi);
        bus.Hsync = 1'b0;
        repeat (lo) tick();
        bus.Hsync = 1'b1;
        repeat (hi) tick();
    endtask

    task automatic start_frame(input logic vf, input logic hf);
        bus.Vflip = vf;
        bus.Hflip = hf;
        bus.Hsync = 1'b1;
        bus.Vsync = 1'b0;
        repeat (2) tick();
        bus.Vsync = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_reset();
        RESET = 1'b0;
        bus.Hsync = 1'b1;
        bus.Vsync = 1'b1;
        bus.Hflip = 1'b0;
        bus.Vflip = 1'b0;
        repeat (3) tick();
        checks++;
        if ({bus.addr, bus.de, bus.x, bus.y, bus.frame_start, bus.short_line} !== 13'd0) begin
            failures++;
            $display("FAIL reset_outputs addr=%0d de=%b x=%0d y=%0d fs=%b sl=%b, all required 0",
                     bus.addr, bus.de, bus.x, bus.y, bus.frame_start, bus.short_line);
        end
        RESET = 1'b1;
        clear_log();
        repeat (20) tick();
        checks++;
        if (q_addr.size() != 0) begin
            failures++;
            $display("FAIL reset_no_de de_cycles=%0d required=0", q_addr.size());
        end
        checks++;
        if (n_fs != 0 || bus.addr !== 5'd0) begin
            failures++;
            $display("FAIL reset_idle fs=%0d addr=%0d required 0/0", n_fs, bus.addr);
        end
    endtask

    task automatic test_normal();
        clear_log();
        start_frame(1'b0, 1'b0);
        checks++;
        if (n_fs != 1) begin
            failures++;
            $display("FAIL normal_fs pulses=%0d required=1", n_fs);
        end
        run_line(2, 16);
        bus.Hsync = 1'b0;
        repeat (2) tick();
        bus.Hsync = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            checks++;
            if (bus.de !== ((i >= 3 && i <= 10) ? 1'b1 : 1'b0)) begin
                failures++;
                $display("FAIL normal_de_timing cycle=%0d de=%b required=%b",
                         i, bus.de, (i >= 3 && i <= 10));
            end
        end
        repeat (3) run_line(2, 16);
        checks++;
        if (q_addr.size() != 32) begin
            failures++;
            $display("FAIL normal_count de_cycles=%0d required=32", q_addr.size());
        end
        for (int i = 0; i < 32 && i < q_addr.size(); i++) begin
            checks++;
            if (q_addr[i] !== 5'(i) || q_x[i] != i % 8 || q_y[i] != i / 8) begin
                failures++;
                $display("FAIL normal_pix i=%0d addr=%0d x=%0d y=%0d required %0d/%0d/%0d",
                         i, q_addr[i], q_x[i], q_y[i], i, i % 8, i / 8);
            end
        end
        checks++;
        if (n_short != 0) begin
            failures++;
            $display("FAIL normal_short pulses=%0d required=0", n_short);
        end
    endtask

    task automatic test_flip(input logic vf, input logic hf);
        logic [4:0] e;
        int         xo;
        clear_log();
        start_frame(vf, hf);
        run_line(2, 16);
        bus.Vflip = ~vf;
        bus.Hflip = ~hf;
        repeat (4) run_line(2, 16);
        checks++;
        if (q_addr.size() != 32) begin
            failures++;
            $display("FAIL flip_count vf=%b hf=%b de_cycles=%0d required=32", vf, hf, q_addr.size());
        end
        for (int i = 0; i < 32 && i < q_addr.size(); i++) begin
            xo = (HF_EN && hf) ? 7 - i % 8 : i % 8;
            e  = 5'((vf ? 3 - i / 8 : i / 8) * 8 + xo);
            checks++;
            if (q_addr[i] !== e || q_x[i] != i % 8) begin
                failures++;
                $display("FAIL flip_pix vf=%b hf=%b i=%0d addr=%0d x=%0d required %0d/%0d",
                         vf, hf, i, q_addr[i], q_x[i], e, i % 8);
            end
        end
    endtask

    task automatic test_short_line();
        clear_log();
        start_frame(1'b0, 1'b0);
        repeat (2) run_line(2, 16);
        run_line(2, 8);
        bus.Hsync = 1'b0;
        tick();
        checks++;
        if (bus.de !== 1'b0 || bus.short_line !== 1'b1 || bus.y !== 2'd3) begin
            failures++;
            $display("FAIL short_cut de=%b sl=%b y=%0d required 0/1/3", bus.de, bus.short_line, bus.y);
        end
        tick();
        checks++;
        if (bus.short_line !== 1'b0) begin
            failures++;
            $display("FAIL short_once sl=%b required=0", bus.short_line);
        end
        run_line(0, 16);
        run_line(2, 16);
        checks++;
        if (q_addr.size() != 29 || n_short != 1) begin
            failures++;
            $display("FAIL short_count de_cycles=%0d pulses=%0d required 29/1", q_addr.size(), n_short);
        end
        for (int i = 16; i < 29 && i < q_addr.size(); i++) begin
            checks++;
            if (q_addr[i] !== ((i < 21) ? 5'(i) : 5'(i + 3))) begin
                failures++;
                $display("FAIL short_pix i=%0d addr=%0d required=%0d", i, q_addr[i], (i < 21) ? i : i + 3);
            end
        end
    endtask

    task automatic test_vsync_mid();
        clear_log();
        start_frame(1'b0, 1'b0);
        run_line(2, 16);
        run_line(2, 6);
        checks++;
        if (q_addr.size() != 11 || q_addr[q_addr.size() - 1] !== 5'd10) begin
            failures++;
            $display("FAIL vmid_partial de_cycles=%0d required=11 ending at addr 10", q_addr.size());
        end
        bus.Vsync = 1'b0;
        tick();
        checks++;
        if (bus.de !== 1'b0 || bus.frame_start !== 1'b1 || bus.short_line !== 1'b0 || bus.y !== 2'd0) begin
            failures++;
            $display("FAIL vmid_cut de=%b fs=%b sl=%b y=%0d required 0/1/0/0",
                     bus.de, bus.frame_start, bus.short_line, bus.y);
        end
        tick();
        checks++;
        if (bus.frame_start !== 1'b0) begin
            failures++;
            $display("FAIL vmid_fs_once fs=%b required=0", bus.frame_start);
        end
        bus.Vsync = 1'b1;
        repeat (2) tick();
        repeat (2) run_line(2, 16);
        bus.Hsync = 1'b0;
        bus.Vsync = 1'b0;
        tick();
        checks++;
        if (bus.y !== 2'd0 || bus.frame_start !== 1'b1 || bus.short_line !== 1'b0) begin
            failures++;
            $display("FAIL vmid_same_edge y=%0d fs=%b sl=%b required 0/1/0",
                     bus.y, bus.frame_start, bus.short_line);
        end
        bus.Hsync = 1'b1;
        tick();
        bus.Vsync = 1'b1;
        repeat (2) tick();
        clear_log();
        run_line(2, 16);
        checks++;
        if (q_addr.size() != 8 || q_addr[0] !== 5'd0 || q_y[0] != 0) begin
            failures++;
            $display("FAIL vmid_restart de_cycles=%0d required=8 starting addr 0 y 0", q_addr.size());
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_flip(1'b1, 1'b0);
        test_flip(1'b0, 1'b1);
        test_flip(1'b1, 1'b1);
        test_short_line();
        test_vsync_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
